// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdown scoreboard and issue control for the
// in-order fetch/dec/op/ex/mem/wb pipeline.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   rs1_dec, rs2_dec, *_used_dec  source registers of the dec instruction
//   rd_dec, rd_used_dec           destination written from the ALU
//   rd_memory_dec                 destination written by a load
//   mem_busy                      freezes the whole pipeline
//   flush                         kills the dec instruction
//   fetch_ena..wb_ena             stage enables (combinational)
//   dec_nop                       bubble into op instead of dec instruction
//   busy_regs                     registers with a pending write
//   stall_count                   saturating count of hazard-stall cycles
module hazard_scoreboard #(
   parameter int unsigned REG_BITS    = 5,
   parameter int unsigned LAT_ALU     = 2,
   parameter int unsigned LAT_MEM     = 3,
   parameter int unsigned STALL_CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [REG_BITS-1:0]      rs1_dec,
   input  logic [REG_BITS-1:0]      rs2_dec,
   input  logic                     rs1_used_dec,
   input  logic                     rs2_used_dec,
   input  logic [REG_BITS-1:0]      rd_dec,
   input  logic                     rd_used_dec,
   input  logic                     rd_memory_dec,
   input  logic                     mem_busy,
   input  logic                     flush,
   output logic                     fetch_ena,
   output logic                     dec_ena,
   output logic                     op_ena,
   output logic                     ex_ena,
   output logic                     mem_ena,
   output logic                     wb_ena,
   output logic                     dec_nop,
   output logic [2**REG_BITS-1:0]   busy_regs,
   output logic [STALL_CNT_W-1:0]   stall_count
);

   localparam int unsigned NREGS = 2**REG_BITS;
   localparam int unsigned CNT_W = $clog2(LAT_MEM + 1);

   // Register 0 is never stored; cnt_full supplies a constant zero for it.
   logic [CNT_W-1:0] cnt_q    [1:NREGS-1];
   logic [CNT_W-1:0] cnt_full [NREGS];

   logic             wr;
   logic [CNT_W-1:0] new_lat;
   logic             raw;
   logic             waw;
   logic             hazard;
   logic             issue;
   logic             stall;

   // Scoreboard view including the hard-wired zero register.
   always_comb begin
      cnt_full[0] = '0;
      for (int unsigned r = 1; r < NREGS; r++) begin
         cnt_full[r] = cnt_q[r];
      end
   end

   // Pending-write vector.
   always_comb begin
      busy_regs = '0;
      for (int unsigned r = 0; r < NREGS; r++) begin
         busy_regs[r] = (cnt_full[r] != '0);
      end
   end

   // Hazard detection on the current (pre-update) scoreboard.
   always_comb begin
      wr      = (rd_used_dec | rd_memory_dec) & (rd_dec != '0);
      new_lat = rd_memory_dec ? CNT_W'(LAT_MEM) : CNT_W'(LAT_ALU);
      raw     = (rs1_used_dec & (rs1_dec != '0) & busy_regs[rs1_dec]) |
                (rs2_used_dec & (rs2_dec != '0) & busy_regs[rs2_dec]);
      // An older write landing after this one would clobber the newer value.
      waw     = wr & (cnt_full[rd_dec] > new_lat);
      hazard  = raw | waw;
   end

   // Issue control: reset, memory freeze, flush, hazard, normal issue.
   always_comb begin
      fetch_ena = 1'b0;
      dec_ena   = 1'b0;
      op_ena    = 1'b0;
      ex_ena    = 1'b0;
      mem_ena   = 1'b0;
      wb_ena    = 1'b0;
      dec_nop   = 1'b0;
      issue     = 1'b0;
      stall     = 1'b0;
      if (rst || mem_busy) begin
         // whole pipeline frozen
      end else if (flush) begin
         fetch_ena = 1'b1;
         dec_ena   = 1'b1;
         op_ena    = 1'b1;
         ex_ena    = 1'b1;
         mem_ena   = 1'b1;
         wb_ena    = 1'b1;
         dec_nop   = 1'b1;
      end else if (hazard) begin
         op_ena    = 1'b1;
         ex_ena    = 1'b1;
         mem_ena   = 1'b1;
         wb_ena    = 1'b1;
         dec_nop   = 1'b1;
         stall     = 1'b1;
      end else begin
         fetch_ena = 1'b1;
         dec_ena   = 1'b1;
         op_ena    = 1'b1;
         ex_ena    = 1'b1;
         mem_ena   = 1'b1;
         wb_ena    = 1'b1;
         issue     = wr;
      end
   end

   // Countdown update: a new issue overrides the decrement of its own entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned r = 1; r < NREGS; r++) begin
            cnt_q[r] <= '0;
         end
         stall_count <= '0;
      end else if (!mem_busy) begin
         for (int unsigned r = 1; r < NREGS; r++) begin
            if (issue && (rd_dec == REG_BITS'(r))) begin
               cnt_q[r] <= new_lat;
            end else if (cnt_q[r] != '0) begin
               cnt_q[r] <= cnt_q[r] - CNT_W'(1);
            end
         end
         if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + STALL_CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (LAT_ALU=2, LAT_MEM=3, 4-bit stall counter
// so saturation is reachable in a short run).
module tb_hazard_scoreboard;

   localparam int unsigned SCW = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rs1_dec, rs2_dec, rd_dec;
   logic        rs1_used_dec, rs2_used_dec, rd_used_dec, rd_memory_dec;
   logic        mem_busy, flush;
   logic        fetch_ena, dec_ena, op_ena, ex_ena, mem_ena, wb_ena, dec_nop;
   logic [31:0] busy_regs;
   logic [SCW-1:0] stall_count;

   int vectors    = 0;
   int miscompares = 0;
   int exp_sc     = 0;

   // {fetch, dec, op, ex, mem, wb, dec_nop}
   localparam logic [6:0] RUN    = 7'b111111_0;
   localparam logic [6:0] STALL  = 7'b001111_1;
   localparam logic [6:0] FREEZE = 7'b000000_0;
   localparam logic [6:0] FLUSH  = 7'b111111_1;

   logic [6:0] ctl;
   assign ctl = {fetch_ena, dec_ena, op_ena, ex_ena, mem_ena, wb_ena, dec_nop};

   hazard_scoreboard #(
      .REG_BITS(5), .LAT_ALU(2), .LAT_MEM(3), .STALL_CNT_W(SCW)
   ) dut (
      .clk(clk), .rst(rst),
      .rs1_dec(rs1_dec), .rs2_dec(rs2_dec),
      .rs1_used_dec(rs1_used_dec), .rs2_used_dec(rs2_used_dec),
      .rd_dec(rd_dec), .rd_used_dec(rd_used_dec), .rd_memory_dec(rd_memory_dec),
      .mem_busy(mem_busy), .flush(flush),
      .fetch_ena(fetch_ena), .dec_ena(dec_ena), .op_ena(op_ena), .ex_ena(ex_ena),
      .mem_ena(mem_ena), .wb_ena(wb_ena), .dec_nop(dec_nop),
      .busy_regs(busy_regs), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are then changed 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                        input logic u2, input logic [4:0] rd, input logic rdu,
                        input logic rdm);
      rs1_dec = r1; rs1_used_dec = u1;
      rs2_dec = r2; rs2_used_dec = u2;
      rd_dec  = rd; rd_used_dec  = rdu; rd_memory_dec = rdm;
      #1;
   endtask

   task automatic idle();
      drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; mem_busy = 1'b0; flush = 1'b0;
      idle();
      check("rst_ctl", 32'(ctl), 32'(FREEZE));
      check("rst_busy", busy_regs, 32'h0);
      check("rst_sc", 32'(stall_count), 32'h0);
      tick(); tick();
      rst = 1'b0;
      #1;
      check("post_rst_ctl", 32'(ctl), 32'(RUN));
      check("post_rst_busy", busy_regs, 32'h0);

      // ALU x5 then consumer rs1=x5: two stall cycles.
      drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
      check("alu_issue", 32'(ctl), 32'(RUN));
      tick();
      drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      check("alu_busy5", busy_regs, 32'h0000_0020);
      check("alu_stall1", 32'(ctl), 32'(STALL));
      tick();
      check("alu_stall2", 32'(ctl), 32'(STALL));
      tick();
      check("alu_go", 32'(ctl), 32'(RUN));
      tick();
      exp_sc = 2;
      check("alu_sc", 32'(stall_count), 32'(exp_sc));
      check("alu_drained", busy_regs, 32'h0);

      // Load x7 then consumer rs2=x7: three stall cycles.
      drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 1'b1);
      tick();
      drive(5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check("ld_stall", 32'(ctl), 32'(STALL));
         tick();
      end
      check("ld_go", 32'(ctl), 32'(RUN));
      tick();
      exp_sc = 5;
      check("ld_sc", 32'(stall_count), 32'(exp_sc));

      // Independent follower after a load issues immediately.
      drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 1'b1);
      tick();
      drive(5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      check("indep_go", 32'(ctl), 32'(RUN));
      tick();
      idle();
      tick(); tick();
      check("indep_drained", busy_regs, 32'h0);
      check("indep_sc", 32'(stall_count), 32'(exp_sc));

      // WAW: load x3, then ALU x3 -> one stall cycle.
      drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b0, 1'b1);
      tick();
      drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
      check("waw_stall", 32'(ctl), 32'(STALL));
      tick();
      check("waw_go", 32'(ctl), 32'(RUN));
      tick();
      idle();
      check("waw_busy_a", busy_regs, 32'h0000_0008);
      tick();
      check("waw_busy_b", busy_regs, 32'h0000_0008);
      tick();
      check("waw_busy_c", busy_regs, 32'h0);
      exp_sc = 6;
      check("waw_sc", 32'(stall_count), 32'(exp_sc));

      // RAW stall on x5 with a 4-cycle memory freeze in the middle.
      drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
      tick();
      drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      check("mb_stall1", 32'(ctl), 32'(STALL));
      tick();
      mem_busy = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         check("mb_freeze", 32'(ctl), 32'(FREEZE));
         check("mb_busy5", busy_regs, 32'h0000_0020);
         tick();
      end
      check("mb_sc_hold", 32'(stall_count), 32'd7);
      mem_busy = 1'b0;
      #1;
      check("mb_stall2", 32'(ctl), 32'(STALL));
      tick();
      check("mb_go", 32'(ctl), 32'(RUN));
      tick();
      exp_sc = 8;
      check("mb_sc", 32'(stall_count), 32'(exp_sc));

      // Flush wins over a RAW hazard; x9 never enters the scoreboard.
      drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
      tick();
      flush = 1'b1;
      drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
      check("fl_ctl", 32'(ctl), 32'(FLUSH));
      tick();
      flush = 1'b0;
      idle();
      check("fl_busy", busy_regs, 32'h0000_0020);
      check("fl_sc", 32'(stall_count), 32'(exp_sc));
      tick();

      // Register 0: never tracked, never a hazard.
      drive(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1);
      check("x0_ctl", 32'(ctl), 32'(RUN));
      tick();
      check("x0_ctl2", 32'(ctl), 32'(RUN));
      check("x0_busy", busy_regs, 32'h0);

      // Repeated load-use stalls drive the counter into saturation.
      for (int k = 0; k < 4; k++) begin
         drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b0, 1'b1);
         tick();
         drive(5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
         for (int i = 0; i < 3; i++) begin
            check("sat_stall", 32'(ctl), 32'(STALL));
            tick();
         end
         check("sat_go", 32'(ctl), 32'(RUN));
         tick();
         exp_sc = (exp_sc + 3 > 15) ? 15 : exp_sc + 3;
         check("sat_sc", 32'(stall_count), 32'(exp_sc));
      end

      // Asynchronous reset mid-operation clears pending writes at once.
      drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
      tick();
      idle();
      check("mid_busy", busy_regs, 32'h0000_0020);
      rst = 1'b1;
      #1;
      check("mid_rst_busy", busy_regs, 32'h0);
      check("mid_rst_sc", 32'(stall_count), 32'h0);
      check("mid_rst_ctl", 32'(ctl), 32'(FREEZE));
      tick();
      rst = 1'b0;
      drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      check("mid_after_ctl", 32'(ctl), 32'(RUN));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
